pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the F/D, D/E, E/M and M/W pipeline register banks and the PC enable. It tracks the multi-cycle multiply/divide unit (MDU) with an internal busy counter. It flushes the pipeline when the M stage raises an exception or interrupt.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_md_busy_counter.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 89 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: operand timing
// encodings, MDU latency defaults, the CP0 EPC index and the operand hazard rule.
package pipe_hazard_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] tstage_t;

  // Tuse value meaning the operand is never read.
  localparam tstage_t TUSE_NONE = 2'd3;
  // Tnew value meaning the result is already available for forwarding.
  localparam tstage_t TNEW_READY = 2'd0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // CP0 register number of EPC.
  localparam reg_idx_t CP0_EPC_IDX = 5'd14;

  // A D-stage source must wait when an in-flight producer of that register
  // will not have its result before the operand is consumed. Register 0 is
  // hardwired and never waits; E and M matches combine by OR.
  function automatic logic operand_hazard(
    input reg_idx_t src,
    input tstage_t  tuse,
    input reg_idx_t e_dst,
    input tstage_t  e_tnew,
    input reg_idx_t m_dst,
    input tstage_t  m_tnew
  );
    if (src == '0 || tuse == TUSE_NONE) return 1'b0;
    return (e_dst == src && e_tnew > tuse) || (m_dst == src && m_tnew > tuse);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. The master modport is
// the pipeline (source of stage information, sink of enables/flushes); the
// slave modport is the controller.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t d_rs_addr;
  reg_idx_t d_rt_addr;
  tstage_t  d_tuse_rs;
  tstage_t  d_tuse_rt;
  logic     d_is_md;
  logic     d_is_eret;
  reg_idx_t e_wr_addr;
  tstage_t  e_tnew;
  logic     e_md_start;
  logic     e_md_is_div;
  logic     e_mtc0_epc;
  reg_idx_t m_wr_addr;
  tstage_t  m_tnew;
  logic     m_mtc0_epc;
  logic     exc_req;

  logic     f_pc_en;
  logic     fd_en;
  logic     fd_flush;
  logic     de_flush;
  logic     em_flush;
  logic     mw_flush;
  logic     md_busy;

  modport master (
    output d_rs_addr, d_rt_addr, d_tuse_rs, d_tuse_rt, d_is_md, d_is_eret,
           e_wr_addr, e_tnew, e_md_start, e_md_is_div, e_mtc0_epc,
           m_wr_addr, m_tnew, m_mtc0_epc, exc_req,
    input  f_pc_en, fd_en, fd_flush, de_flush, em_flush, mw_flush, md_busy
  );

  modport slave (
    input  d_rs_addr, d_rt_addr, d_tuse_rs, d_tuse_rt, d_is_md, d_is_eret,
           e_wr_addr, e_tnew, e_md_start, e_md_is_div, e_mtc0_epc,
           m_wr_addr, m_tnew, m_mtc0_epc, exc_req,
    output f_pc_en, fd_en, fd_flush, de_flush, em_flush, mw_flush, md_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// MDU busy tracker: loads the operation latency on a start, counts down to
// zero, and reports busy while nonzero. Reset aborts a running count.
module md_busy_counter #(
  parameter int CNT_W       = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt;

  // Load on start, otherwise count down to zero.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)              md_cnt <= '0;
    else if (load)          md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != '0)  md_cnt <= md_cnt - CNT_W'(1);
  end

  // Busy is forced low while reset is held, before the clearing edge arrives.
  assign busy = (md_cnt != '0) && !reset;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls on
// load-use/MDU/eret hazards and flushes on M-stage exceptions.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic md_busy;
  logic md_load;
  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_eret;
  logic stall;

  // An exception squashes the E-stage instruction, so its MDU start is dropped.
  assign md_load = hz.e_md_start && !hz.exc_req;

  md_busy_counter #(
    .CNT_W      (CNT_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .is_div (hz.e_md_is_div),
    .busy   (md_busy)
  );

  assign stall_rs   = operand_hazard(hz.d_rs_addr, hz.d_tuse_rs, hz.e_wr_addr,
                                     hz.e_tnew, hz.m_wr_addr, hz.m_tnew);
  assign stall_rt   = operand_hazard(hz.d_rt_addr, hz.d_tuse_rt, hz.e_wr_addr,
                                     hz.e_tnew, hz.m_wr_addr, hz.m_tnew);
  assign stall_md   = hz.d_is_md && (md_busy || hz.e_md_start);
  assign stall_eret = hz.d_is_eret && (hz.e_mtc0_epc || hz.m_mtc0_epc);
  assign stall      = stall_rs || stall_rt || stall_md || stall_eret;

  assign hz.md_busy = md_busy;

  // Pipeline control: exception flush beats stall, stall beats normal flow.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    hz.f_pc_en  = 1'b1;
    hz.fd_en    = 1'b1;
    hz.fd_flush = 1'b0;
    hz.de_flush = 1'b0;
    hz.em_flush = 1'b0;
    hz.mw_flush = 1'b0;
    if (hz.exc_req) begin
      hz.fd_flush = 1'b1;
      hz.de_flush = 1'b1;
      hz.em_flush = 1'b1;
      hz.mw_flush = 1'b1;
    end else if (stall) begin
      hz.f_pc_en  = 1'b0;
      hz.fd_en    = 1'b0;
      hz.de_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters: exception cycles, and stalls not overridden by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.exc_req) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random
// run, all compared against a cycle-indexed reference model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic       reset;
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md, is_eret;
    logic [4:0] e_wr;
    logic [1:0] e_tnew;
    logic       e_start, e_div, e_epc;
    logic [4:0] m_wr;
    logic [1:0] m_tnew;
    logic       m_epc, exc;
  } stim_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz),
                        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {f_pc_en, fd_en, fd_flush, de_flush, em_flush, mw_flush, md_busy}
  wire [6:0] obs = {hz.f_pc_en, hz.fd_en, hz.fd_flush, hz.de_flush,
                    hz.em_flush, hz.mw_flush, hz.md_busy};

  // Reference model state: MDU busy is "cycle index <= busy_until".
  stim_t       cur;
  int          cyc = 0;
  int          busy_until = -1;
  logic [6:0]  exp_out;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic stim_t idle();
    stim_t s;
    s.reset = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.tuse_rs = 2'd3; s.tuse_rt = 2'd3;
    s.is_md = 1'b0; s.is_eret = 1'b0; s.e_wr = 5'd0; s.e_tnew = 2'd0;
    s.e_start = 1'b0; s.e_div = 1'b0; s.e_epc = 1'b0; s.m_wr = 5'd0;
    s.m_tnew = 2'd0; s.m_epc = 1'b0; s.exc = 1'b0;
    return s;
  endfunction

  function automatic logic src_wait(logic [4:0] a, logic [1:0] tuse, stim_t s);
    if (a == 5'd0) return 1'b0;
    return (s.e_wr == a && s.e_tnew > tuse) || (s.m_wr == a && s.m_tnew > tuse);
  endfunction

  function automatic logic model_busy(stim_t s);
    return !s.reset && (cyc <= busy_until);
  endfunction

  function automatic logic model_stall(stim_t s);
    return src_wait(s.rs, s.tuse_rs, s) || src_wait(s.rt, s.tuse_rt, s) ||
           (s.is_md && (model_busy(s) || s.e_start)) ||
           (s.is_eret && (s.e_epc || s.m_epc));
  endfunction

  function automatic logic [6:0] model_out(stim_t s);
    logic b;
    b = model_busy(s);
    if (s.exc)              return {6'b111111, b};
    else if (model_stall(s)) return {6'b000100, b};
    else                    return {6'b110000, b};
  endfunction

  task automatic apply(input stim_t s);
    cur = s;
    reset          = s.reset;
    hz.d_rs_addr   = s.rs;      hz.d_rt_addr   = s.rt;
    hz.d_tuse_rs   = s.tuse_rs; hz.d_tuse_rt   = s.tuse_rt;
    hz.d_is_md     = s.is_md;   hz.d_is_eret   = s.is_eret;
    hz.e_wr_addr   = s.e_wr;    hz.e_tnew      = s.e_tnew;
    hz.e_md_start  = s.e_start; hz.e_md_is_div = s.e_div;
    hz.e_mtc0_epc  = s.e_epc;   hz.m_wr_addr   = s.m_wr;
    hz.m_tnew      = s.m_tnew;  hz.m_mtc0_epc  = s.m_epc;
    hz.exc_req     = s.exc;
    #1;
    exp_out = model_out(s);
  endtask

  // Advance one clock and move the model to the next cycle.
  task automatic tick();
    @(posedge clk);
    if (cur.reset) begin
      busy_until = -1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (cur.exc) begin
        if (m_flush != 32'hFFFFFFFF) m_flush = m_flush + 1;
      end else if (model_stall(cur)) begin
        if (m_stall != 32'hFFFFFFFF) m_stall = m_stall + 1;
      end
      if (cur.e_start && !cur.exc) busy_until = cyc + (cur.e_div ? DIV_N : MULT_N);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    s = idle(); s.reset = 1'b1;
    apply(s);
    checks++;
    if (obs !== exp_out) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_out); end
    tick();
    s.is_md = 1'b1; s.e_start = 1'b1; s.e_div = 1'b1;
    apply(s);
    checks++;
    if (obs !== exp_out) begin failures++; $display("FAIL reset_md_start got=%b exp=%b", obs, exp_out); end
    tick();
    s = idle();
    apply(s);
    checks++;
    if (obs !== 7'b1100000) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, 7'b1100000); end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    stim_t s;
    s = idle(); s.e_wr = 5'd8; s.e_tnew = 2'd2; s.rs = 5'd8; s.tuse_rs = 2'd0;
    apply(s);
    checks++;
    if (obs !== 7'b0001000) begin failures++; $display("FAIL load_use_rs got=%b exp=%b", obs, 7'b0001000); end
    tick();
    s = idle(); s.m_wr = 5'd9; s.m_tnew = 2'd1; s.rt = 5'd9; s.tuse_rt = 2'd0;
    apply(s);
    checks++;
    if (obs !== exp_out) begin failures++; $display("FAIL load_use_m_rt got=%b exp=%b", obs, exp_out); end
    tick();
    s = idle(); s.e_wr = 5'd8; s.e_tnew = 2'd1; s.rs = 5'd8; s.tuse_rs = 2'd1;
    apply(s);
    checks++;
    if (obs !== 7'b1100000) begin failures++; $display("FAIL tnew_eq_tuse got=%b exp=%b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_mdu_div();
    stim_t s;
    int stall_cycles = 0;
    int busy_cycles = 0;
    logic released = 1'b0;
    s = idle(); s.e_start = 1'b1; s.e_div = 1'b1; s.is_md = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply(s);
      checks++;
      if (obs !== exp_out) begin failures++; $display("FAIL div_cycle%0d got=%b exp=%b", i, obs, exp_out); end
      if (obs[6] == 1'b0) stall_cycles++;
      if (obs[0] == 1'b1) busy_cycles++;
      if (obs[6] == 1'b1) begin released = 1'b1; break; end
      tick();
      s.e_start = 1'b0;
    end
    checks++;
    if (!released || stall_cycles != DIV_N + 1) begin
      failures++; $display("FAIL div_stall_len got=%0d exp=%0d", stall_cycles, DIV_N + 1);
    end
    checks++;
    if (busy_cycles != DIV_N) begin
      failures++; $display("FAIL div_busy_len got=%0d exp=%0d", busy_cycles, DIV_N);
    end
    tick();
  endtask

  task automatic test_exc_md();
    stim_t s;
    int busy_cycles = 0;
    s = idle(); s.e_start = 1'b1;
    apply(s);
    tick();
    s = idle(); s.exc = 1'b1; s.is_md = 1'b1; s.e_start = 1'b1; s.e_div = 1'b1;
    apply(s);
    checks++;
    if (obs !== 7'b1111111) begin failures++; $display("FAIL exc_flush got=%b exp=%b", obs, 7'b1111111); end
    tick();
    s = idle();
    for (int i = 0; i < 15; i++) begin
      apply(s);
      checks++;
      if (obs !== exp_out) begin failures++; $display("FAIL exc_after%0d got=%b exp=%b", i, obs, exp_out); end
      if (obs[0]) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != MULT_N - 1) begin
      failures++; $display("FAIL exc_no_load got=%0d exp=%0d", busy_cycles, MULT_N - 1);
    end
  endtask

  task automatic test_zero_reg();
    stim_t s;
    s = idle(); s.e_wr = 5'd0; s.e_tnew = 2'd2; s.rs = 5'd0; s.tuse_rs = 2'd0;
    s.m_wr = 5'd0; s.m_tnew = 2'd2; s.rt = 5'd0; s.tuse_rt = 2'd0;
    apply(s);
    checks++;
    if (obs !== 7'b1100000) begin failures++; $display("FAIL zero_reg got=%b exp=%b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_eret();
    stim_t s;
    s = idle(); s.is_eret = 1'b1; s.m_epc = 1'b1;
    apply(s);
    checks++;
    if (obs !== 7'b0001000) begin failures++; $display("FAIL eret_m_epc got=%b exp=%b", obs, 7'b0001000); end
    tick();
    s.m_epc = 1'b0;
    apply(s);
    checks++;
    if (obs !== 7'b1100000) begin failures++; $display("FAIL eret_proceed got=%b exp=%b", obs, 7'b1100000); end
    tick();
    s.e_epc = 1'b1;
    apply(s);
    checks++;
    if (obs !== exp_out) begin failures++; $display("FAIL eret_e_epc got=%b exp=%b", obs, exp_out); end
    tick();
  endtask

  task automatic test_reset_mid_count();
    stim_t s;
    s = idle(); s.e_start = 1'b1;
    apply(s);
    tick();
    s = idle();
    apply(s); tick();
    apply(s); tick();
    checks++;
    if (obs[0] !== 1'b1) begin failures++; $display("FAIL mid_count_busy got=%b exp=1", obs[0]); end
    s.reset = 1'b1;
    apply(s);
    tick();
    s.reset = 1'b0; s.is_md = 1'b1;
    apply(s);
    checks++;
    if (obs !== 7'b1100000) begin failures++; $display("FAIL reset_abort got=%b exp=%b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.reset   = ($urandom_range(0, 49) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.tuse_rs = 2'($urandom_range(0, 3));
      s.tuse_rt = 2'($urandom_range(0, 3));
      s.is_md   = ($urandom_range(0, 3) == 0);
      s.is_eret = ($urandom_range(0, 7) == 0);
      s.e_wr    = 5'($urandom_range(0, 3));
      s.e_tnew  = 2'($urandom_range(0, 3));
      s.e_start = ($urandom_range(0, 5) == 0);
      s.e_div   = 1'($urandom_range(0, 1));
      s.e_epc   = ($urandom_range(0, 7) == 0);
      s.m_wr    = 5'($urandom_range(0, 3));
      s.m_tnew  = 2'($urandom_range(0, 3));
      s.m_epc   = ($urandom_range(0, 7) == 0);
      s.exc     = ($urandom_range(0, 9) == 0);
      apply(s);
      checks++;
      if (obs !== exp_out) begin failures++; $display("FAIL random%0d got=%b exp=%b", i, obs, exp_out); end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        failures++;
        $display("FAIL random_stats%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mdu_div();
    test_exc_md();
    test_zero_reg();
    test_eret();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
